// File: rtl/serial_adder_if.sv
// Operand/result bundle between a controller (master) and serial_adder (slave).
// The sub_i mode bit exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_i;
`endif
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub_i,
`endif
    output start_i, a_i, b_i, cin_i,
    input  busy_o, done_o, sum_o, cout_o
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub_i,
`endif
    input  start_i, a_i, b_i, cin_i,
    output busy_o, done_o, sum_o, cout_o
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial a+b+cin over WIDTH/DIGIT cycles (done one cycle later); SERIAL_ADDER_SUB_EN adds a-b mode.
// start is only accepted in IDLE/DONE; a start during RUN is dropped, never queued.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int L  = WIDTH / DIGIT;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert b and inject the +1 through the carry.
  assign b_load = bus.sub_i ? ~bus.b_i : bus.b_i;
  assign c_load = bus.sub_i ? 1'b1 : bus.cin_i;
`else
  assign b_load = bus.b_i;
  assign c_load = bus.cin_i;
`endif

  assign dsum = {1'b0, a_sr_q[DIGIT-1:0]} + {1'b0, b_sr_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          a_sr_d  = bus.a_i;
          b_sr_d  = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> DIGIT;
        b_sr_d  = b_sr_q >> DIGIT;
        // New digit enters at the MSB end so the LSB digit lands at bit 0 after L shifts.
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = dsum[DIGIT];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy_o = (state_q == RUN);
  assign bus.done_o = (state_q == DONE);
  assign bus.sum_o  = sum_q;
  assign bus.cout_o = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Five serial_adder instances (W8D1, W8D4, W4D1, W4D2, W8D2) driven concurrently;
// a forked monitor pops expected {cout,sum} from per-instance queues on every done.
module tb_serial_adder;
  localparam int N = 5;
`ifdef SERIAL_ADDER_SUB_EN
  localparam int SUB_EN = 1;
`else
  localparam int SUB_EN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_s[N], b_s[N], sum_s[N];
  logic       cin_s[N], sub_s[N], start_s[N], rst_s[N];
  logic       busy_s[N], done_s[N], cout_s[N];
  int         exp_q[N][$];
  int         checks = 0;
  int         failures = 0;

  generate
    for (genvar g = 0; g < N; g++) begin : u
      localparam int W = (g == 2 || g == 3) ? 4 : 8;
      localparam int D = (g == 0 || g == 2) ? 1 : (g == 1) ? 4 : 2;
      serial_adder_if #(.WIDTH(W)) sa_if ();
      assign sa_if.start_i = start_s[g];
      assign sa_if.a_i     = a_s[g][W-1:0];
      assign sa_if.b_i     = b_s[g][W-1:0];
      assign sa_if.cin_i   = cin_s[g];
`ifdef SERIAL_ADDER_SUB_EN
      assign sa_if.sub_i   = sub_s[g];
`endif
      assign busy_s[g] = sa_if.busy_o;
      assign done_s[g] = sa_if.done_o;
      assign sum_s[g]  = 8'(sa_if.sum_o);
      assign cout_s[g] = sa_if.cout_o;
      serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk (clk),
        .rst (rst_s[g]),
        .bus (sa_if)
      );
    end
  endgenerate

  function automatic int w_of(int g);
    return (g == 2 || g == 3) ? 4 : 8;
  endfunction

  function automatic int l_of(int g);
    case (g)
      0: return 8;
      1: return 2;
      2: return 4;
      3: return 2;
      default: return 4;
    endcase
  endfunction

  // Reference: plain integer arithmetic; bit w of the result is cout.
  function automatic int model(int g, int a, int b, int cin, int sub);
    if (sub != 0) return a - b + (1 << w_of(g));
    return a + b + cin;
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        if (done_s[g]) begin
          int got;
          got = (int'(cout_s[g]) << w_of(g)) | int'(sum_s[g]);
          check($sformatf("dut%0d_busy_with_done", g), int'(busy_s[g]), 0);
          if (exp_q[g].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dut%0d_unexpected_done: got result 0x%0h with nothing expected", g, got);
          end else begin
            check($sformatf("dut%0d_result", g), got, exp_q[g].pop_front());
          end
        end
      end
    end
  endtask

  task automatic do_op(int g, int a, int b, int cin, int sub);
    int lat = 0;
    int nbusy = 0;
    bit seen = 0;
    a_s[g] = 8'(a); b_s[g] = 8'(b); cin_s[g] = cin[0]; sub_s[g] = sub[0];
    start_s[g] = 1'b1;
    @(posedge clk);
    exp_q[g].push_back(model(g, a, b, cin, sub));
    for (int i = 0; i < 4 * l_of(g) + 10 && !seen; i++) begin
      @(negedge clk);
      start_s[g] = 1'b0;
      lat++;
      if (busy_s[g]) nbusy++;
      if (done_s[g]) seen = 1;
    end
    check($sformatf("dut%0d_latency", g), seen ? lat : -1, l_of(g) + 1);
    check($sformatf("dut%0d_busy_cycles", g), nbusy, l_of(g));
  endtask

  task automatic wait_done(int g, string name);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done_s[g]) seen = 1;
    end
    check(name, int'(seen), 1);
  endtask

  task automatic expect_quiet(int g, int n, string name);
    int cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done_s[g]) cnt++;
    end
    check(name, cnt, 0);
  endtask

  initial begin
    for (int g = 0; g < N; g++) begin
      rst_s[g] = 1'b1; start_s[g] = 1'b0; a_s[g] = '0; b_s[g] = '0;
      cin_s[g] = 1'b0; sub_s[g] = 1'b0;
    end
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check($sformatf("dut%0d_rst_busy", g), int'(busy_s[g]), 0);
      check($sformatf("dut%0d_rst_done", g), int'(done_s[g]), 0);
      check($sformatf("dut%0d_rst_sum", g), int'(sum_s[g]), 0);
      check($sformatf("dut%0d_rst_cout", g), int'(cout_s[g]), 0);
      rst_s[g] = 1'b0;
    end
    @(negedge clk);

    fork
      begin : p0
        do_op(0, 'h5A, 'h3C, 0, 0);
        do_op(0, 'hFF, 'h00, 1, 0);
        repeat (5) begin
          @(negedge clk);
          check("hold_sum", int'(sum_s[0]), 'h00);
          check("hold_cout", int'(cout_s[0]), 1);
        end
        // start during RUN must be dropped
        a_s[0] = 8'h11; b_s[0] = 8'h22; cin_s[0] = 1'b0; start_s[0] = 1'b1;
        @(posedge clk);
        exp_q[0].push_back(model(0, 'h11, 'h22, 0, 0));
        @(negedge clk); start_s[0] = 1'b0;
        @(negedge clk); a_s[0] = 8'hFF; b_s[0] = 8'hFF; start_s[0] = 1'b1;
        repeat (2) @(negedge clk);
        start_s[0] = 1'b0;
        wait_done(0, "ignored_start_done");
        expect_quiet(0, 15, "ignored_start_no_extra_done");
        // abort with reset on the 4th RUN cycle
        a_s[0] = 8'h80; b_s[0] = 8'h80; start_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_s[0] = 1'b1;
        #1;
        check("abort_busy", int'(busy_s[0]), 0);
        check("abort_done", int'(done_s[0]), 0);
        check("abort_sum", int'(sum_s[0]), 0);
        check("abort_cout", int'(cout_s[0]), 0);
        @(negedge clk); rst_s[0] = 1'b0;
        expect_quiet(0, 15, "abort_no_done");
        do_op(0, 'h80, 'h80, 0, 0);
        repeat (30) do_op(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), 0);
      end
      begin : p1
        int lat;
        bit seen;
        do_op(1, 'hF0, 'h1F, 0, 0);
        // back-to-back with start held high
        a_s[1] = 8'h33; b_s[1] = 8'h44; cin_s[1] = 1'b0; start_s[1] = 1'b1;
        @(posedge clk);
        exp_q[1].push_back(model(1, 'h33, 'h44, 0, 0));
        @(negedge clk); a_s[1] = 8'h01; b_s[1] = 8'h01;
        wait_done(1, "b2b_first_done");
        @(posedge clk);
        exp_q[1].push_back(model(1, 'h01, 'h01, 0, 0));
        lat = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          start_s[1] = 1'b0;
          lat++;
          if (done_s[1]) seen = 1;
        end
        check("b2b_done_gap", seen ? lat : -1, 3);
        repeat (30) do_op(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), 0);
      end
      begin : p2
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
              do_op(2, a, b, c, 0);
      end
      begin : p3
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
              do_op(3, a, b, c, 0);
      end
      begin : p4
        if (SUB_EN != 0) begin
          do_op(4, 'h10, 'h01, 0, 1);
          do_op(4, 'h01, 'h02, 0, 1);
        end
        repeat (30) do_op(4, $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 1), (SUB_EN != 0) ? $urandom_range(0, 1) : 0);
      end
    join

    repeat (10) @(negedge clk);
    for (int g = 0; g < N; g++)
      check($sformatf("dut%0d_pending_results", g), exp_q[g].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial adder: adds two WIDTH-bit operands plus a carry-in over WIDTH/DIGIT clock cycles. Each cycle, one DIGIT-bit slice is added through a registered carry. It is the sequential successor to the single-bit gate-level full adder cell. It serves datapaths where a full-width ripple or carry-lookahead adder costs too much area and multi-cycle latency is acceptable. A start/busy/done handshake connects it to a controller.

## Interface
- WIDTH, 8: operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1: bits processed per clock cycle; 1 gives a pure bit-serial adder, and DIGIT=WIDTH gives a single-cycle registered adder.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising edge while in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge only.
- b  input  WIDTH  operand B; captured on the accepting edge only.
- cin  input  1  carry-in; captured on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; high for the one cycle in DONE.
- sum  output  WIDTH  result; held from DONE until the next accepted start.
- cout  output  1  final carry-out; held with sum.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE with all of the following cleared to 0: busy, done, sum, cout, the carry register, the digit counter and the operand shift registers.
- IDLE → RUN on start=1:
  - load a and b into the operand shift registers;
  - load cin into the carry register;
  - clear the digit counter.
- RUN, each cycle:
  - compute {c, s} = a_sr[DIGIT-1:0] + b_sr[DIGIT-1:0] + carry, a (DIGIT+1)-bit result;
  - shift a_sr and b_sr right by DIGIT;
  - shift s into the sum register from the MSB end, so the whole register shifts right by DIGIT;
  - set carry ← c and increment the counter.
- RUN → DONE on the cycle that processes digit index WIDTH/DIGIT-1. On that same edge, the final carry is written to cout.
- DONE → RUN if start=1 (back-to-back operation; new operands are loaded). Otherwise DONE → IDLE.
- A start asserted during RUN is ignored and is not queued. Operand inputs change freely during RUN without effect.
- During RUN, sum holds partially shifted data and is not valid. sum and cout are valid only from DONE onward.
- The counter width is clog2(WIDTH/DIGIT), with a minimum of 1 bit. Any carry out of the top digit is reported only through cout; there is no wrap into the next operation.

## Timing
- Latency: start is accepted on edge 0, and digits are processed on edges 1..L, where L = WIDTH/DIGIT. done is high in the cycle following edge L.
- Throughput: one result every L+1 cycles with start held high continuously.
- busy is high from the cycle after edge 0 through the cycle after edge L-1. busy and done are never high together.
- Asserting rst mid-operation immediately aborts the operation and clears all outputs. No done pulse is produced for the aborted request. The first start after rst deasserts is accepted normally.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - adds input port sub (1 bit), captured with the operands;
  - when sub=1, b is loaded bit-inverted and the carry register is loaded with 1 (cin is ignored), so the block computes a − b;
  - in subtract mode, cout=1 means no borrow.
- SERIAL_ADDER_SUB_EN undefined: the sub port is absent and the block performs addition only.

## Test plan
- WIDTH=8, DIGIT=1; a=0x5A, b=0x3C, cin=0; pulse start → done pulse 9 cycles after the accepting edge, sum=0x96, cout=0; busy high for exactly 8 cycles.
- WIDTH=8, DIGIT=1; a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1; sum and cout remain held through 5 idle cycles.
- WIDTH=8, DIGIT=4; a=0xF0, b=0x1F, cin=0 → done 3 cycles after acceptance, sum=0x0F, cout=1. Then, with start held high continuously, a second operation a=0x01, b=0x01 → sum=0x02 exactly 3 cycles after the first done.
- WIDTH=8, DIGIT=1: pulse start with a=0x11, b=0x22; during RUN, assert start with a=0xFF, b=0xFF → the second request is ignored and the result is sum=0x33. Then start a=0x80, b=0x80, and assert rst for one cycle on the 4th RUN cycle → busy, done, sum and cout read 0 immediately, and no done pulse follows.
- With SERIAL_ADDER_SUB_EN: WIDTH=8, DIGIT=2; a=0x10, b=0x01, sub=1 → sum=0x0F, cout=1. Then a=0x01, b=0x02, sub=1 → sum=0xFF, cout=0.
- Exhaustive check at WIDTH=4, DIGIT=1 and DIGIT=2: all 512 combinations of a, b and cin against a reference sum {cout, sum} = a + b + cin.
